// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : Memory-access stage of the 5-stage pipeline. Drives the
//                data-memory request/acknowledge interface, stalls upstream
//                while a load or store waits on memory, aborts accesses that
//                exceed a wait bound, and registers the selected writeback
//                result into the MA/WB register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
   parameter int unsigned MAX_WAIT = 15,   // unacknowledged cycles before abort (1..255)
   parameter int unsigned CNT_W    = 8     // wait-counter width, 2**CNT_W > MAX_WAIT
) (
   input  logic        clk,
   input  logic        rst,
   // EX/MA register outputs
   input  logic [1:0]  M_sel_result,
   input  logic        M_we_dm,
   input  logic        M_we_rf,
   input  logic [31:0] M_alu_o,
   input  logic [31:0] M_dm_wd,
   input  logic [4:0]  M_rf_a3,
   input  logic [31:0] M_PC_P4,
   input  logic [31:0] M_ext,
   // data-memory interface
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack,
   // pipeline control
   output logic        ma_stall,
   // MA/WB register
   output logic [31:0] W_result,
   output logic [4:0]  W_rf_a3,
   output logic        W_we_rf,
   output logic        dm_timeout
);

   // Result-select encoding
   localparam logic [1:0] c_SEL_ALU = 2'b00;
   localparam logic [1:0] c_SEL_MEM = 2'b01;
   localparam logic [1:0] c_SEL_PC4 = 2'b10;
   localparam logic [1:0] c_SEL_IMM = 2'b11;

   // Counter value at which an outstanding access is abandoned
   localparam logic [CNT_W-1:0] c_MAX_WAIT = CNT_W'(MAX_WAIT);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_timeout;
   logic             w_timeout_nxt;

   logic             w_mem_op;
   logic             w_abort;
   logic             w_stall;
   logic [31:0]      w_result_mux;

   logic [31:0]      r_w_result;
   logic [4:0]       r_w_rf_a3;
   logic             r_w_we_rf;

   // A store, or a load selecting memory data, needs the data memory
   assign w_mem_op = M_we_dm | (M_sel_result == c_SEL_MEM);

   // Abort fires in the cycle after MAX_WAIT unacknowledged request cycles
   assign w_abort  = (r_state == ST_WAIT) & (r_cnt == c_MAX_WAIT);

   // Stall is combinational so a same-cycle acknowledge costs nothing
   assign w_stall  = w_mem_op & ~dm_ack & ~w_abort & ~rst;

   assign dm_req     = w_mem_op & ~w_abort & ~rst;
   assign dm_we      = M_we_dm;
   assign dm_addr    = M_alu_o;
   assign dm_wdata   = M_dm_wd;
   assign ma_stall   = w_stall;
   assign dm_timeout = r_timeout;
   assign W_result   = r_w_result;
   assign W_rf_a3    = r_w_rf_a3;
   assign W_we_rf    = r_w_we_rf;

   // State, wait counter and sticky timeout flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   // Next-state logic for the memory handshake
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_timeout_nxt = r_timeout;
      case (r_state)
         ST_IDLE: begin
            if (w_mem_op & ~dm_ack) begin
               w_state_nxt = ST_WAIT;
               w_cnt_nxt   = CNT_W'(1);
            end else begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         ST_WAIT: begin
            if (w_abort) begin
               // An acknowledge arriving in the abort cycle is ignored
               w_state_nxt   = ST_IDLE;
               w_cnt_nxt     = '0;
               w_timeout_nxt = 1'b1;
            end else if (dm_ack) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = ST_WAIT;
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Writeback result selection
   always_comb begin
      w_result_mux = M_alu_o;
      case (M_sel_result)
         c_SEL_ALU: w_result_mux = M_alu_o;
         c_SEL_MEM: w_result_mux = dm_rdata;
         c_SEL_PC4: w_result_mux = M_PC_P4;
         c_SEL_IMM: w_result_mux = M_ext;
         default:   w_result_mux = M_alu_o;
      endcase
   end

   // MA/WB register: bubble while stalled or aborting, otherwise advance
   always_ff @(posedge clk) begin
      if (rst) begin
         r_w_result <= '0;
         r_w_rf_a3  <= '0;
         r_w_we_rf  <= 1'b0;
      end else if (w_stall | w_abort) begin
         r_w_we_rf  <= 1'b0;
      end else begin
         r_w_result <= w_result_mux;
         r_w_rf_a3  <= M_rf_a3;
         r_w_we_rf  <= M_we_rf & (M_rf_a3 != 5'd0);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_stage
//  Description : Self-checking bench for mem_access_stage. Each instruction
//                is described by its operands and a memory latency; the
//                expected per-cycle handshake and MA/WB contents are derived
//                from that transaction description.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

   localparam int MAX_WAIT = 15;
   localparam int CNT_W    = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  M_sel_result;
   logic        M_we_dm;
   logic        M_we_rf;
   logic [31:0] M_alu_o;
   logic [31:0] M_dm_wd;
   logic [4:0]  M_rf_a3;
   logic [31:0] M_PC_P4;
   logic [31:0] M_ext;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        ma_stall;
   logic [31:0] W_result;
   logic [4:0]  W_rf_a3;
   logic        W_we_rf;
   logic        dm_timeout;

   mem_access_stage #(
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .M_sel_result (M_sel_result),
      .M_we_dm      (M_we_dm),
      .M_we_rf      (M_we_rf),
      .M_alu_o      (M_alu_o),
      .M_dm_wd      (M_dm_wd),
      .M_rf_a3      (M_rf_a3),
      .M_PC_P4      (M_PC_P4),
      .M_ext        (M_ext),
      .dm_req       (dm_req),
      .dm_we        (dm_we),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_rdata     (dm_rdata),
      .dm_ack       (dm_ack),
      .ma_stall     (ma_stall),
      .W_result     (W_result),
      .W_rf_a3      (W_rf_a3),
      .W_we_rf      (W_we_rf),
      .dm_timeout   (dm_timeout)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference view of the MA/WB register and sticky flag
   logic [31:0] exp_result;
   logic [4:0]  exp_a3;
   logic        exp_we;
   logic        exp_to;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic check_w(input string tag);
      chk({tag, ".W_result"},   W_result,         exp_result);
      chk({tag, ".W_rf_a3"},    {27'd0, W_rf_a3}, {27'd0, exp_a3});
      chk({tag, ".W_we_rf"},    {31'd0, W_we_rf}, {31'd0, exp_we});
      chk({tag, ".dm_timeout"}, {31'd0, dm_timeout}, {31'd0, exp_to});
   endtask

   task automatic check_bus(input string tag, input logic req, input logic stall);
      chk({tag, ".dm_req"},   {31'd0, dm_req},   {31'd0, req});
      chk({tag, ".ma_stall"}, {31'd0, ma_stall}, {31'd0, stall});
      chk({tag, ".dm_we"},    {31'd0, dm_we},    {31'd0, M_we_dm});
      chk({tag, ".dm_addr"},  dm_addr,  M_alu_o);
      chk({tag, ".dm_wdata"}, dm_wdata, M_dm_wd);
   endtask

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] alu,
                                        input logic [31:0] rd, input logic [31:0] pc4,
                                        input logic [31:0] ext);
      case (sel)
         2'b00:   return alu;
         2'b01:   return rd;
         2'b10:   return pc4;
         default: return ext;
      endcase
   endfunction

   // One instruction through MA. lat = cycles without ack before the ack;
   // lat >= MAX_WAIT means memory never answers in time.
   task automatic issue(input string tag, input logic [1:0] sel, input logic we_dm,
                        input logic we_rf, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] a3, input logic [31:0] pc4, input logic [31:0] ext,
                        input int lat, input logic ack_abort);
      logic        mem;
      logic [31:0] rd;
      int          waits;
      mem          = we_dm | (sel == 2'b01);
      M_sel_result = sel;
      M_we_dm      = we_dm;
      M_we_rf      = we_rf;
      M_alu_o      = alu;
      M_dm_wd      = wd;
      M_rf_a3      = a3;
      M_PC_P4      = pc4;
      M_ext        = ext;
      if (!mem) begin
         dm_ack   = 1'b0;
         rd       = $urandom;
         dm_rdata = rd;
         @(negedge clk);
         check_bus(tag, 1'b0, 1'b0);
         @(posedge clk); #1;
         exp_result = pick(sel, alu, rd, pc4, ext);
         exp_a3     = a3;
         exp_we     = we_rf & (a3 != 5'd0);
         check_w(tag);
      end else begin
         waits = (lat >= MAX_WAIT) ? MAX_WAIT : lat;
         for (int c = 0; c < waits; c++) begin
            dm_ack   = 1'b0;
            dm_rdata = $urandom;
            @(negedge clk);
            check_bus({tag, ".wait"}, 1'b1, 1'b1);
            @(posedge clk); #1;
            exp_we = 1'b0;
            check_w({tag, ".wait"});
         end
         if (lat < MAX_WAIT) begin
            rd       = $urandom;
            dm_ack   = 1'b1;
            dm_rdata = rd;
            @(negedge clk);
            check_bus({tag, ".ack"}, 1'b1, 1'b0);
            @(posedge clk); #1;
            exp_result = pick(sel, alu, rd, pc4, ext);
            exp_a3     = a3;
            exp_we     = we_rf & (a3 != 5'd0);
            check_w({tag, ".done"});
         end else begin
            dm_ack   = ack_abort;
            dm_rdata = $urandom;
            @(negedge clk);
            check_bus({tag, ".abort"}, 1'b0, 1'b0);
            @(posedge clk); #1;
            exp_we = 1'b0;
            exp_to = 1'b1;
            check_w({tag, ".abort"});
         end
         dm_ack = 1'b0;
      end
   endtask

   initial begin
      logic [1:0]  r_sel;
      logic        r_wdm;
      logic [4:0]  r_a3;
      int          r_lat;
      int          kind;

      // Reset with a pending load presented: request must stay low
      rst          = 1'b1;
      M_sel_result = 2'b01;
      M_we_dm      = 1'b0;
      M_we_rf      = 1'b1;
      M_alu_o      = 32'h0000_0040;
      M_dm_wd      = 32'h0;
      M_rf_a3      = 5'd3;
      M_PC_P4      = 32'h0;
      M_ext        = 32'h0;
      dm_rdata     = 32'h0;
      dm_ack       = 1'b0;
      exp_result   = 32'h0;
      exp_a3       = 5'd0;
      exp_we       = 1'b0;
      exp_to       = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check_bus("reset", 1'b0, 1'b0);
      @(posedge clk); #1;
      check_w("reset");
      rst = 1'b0;

      // Directed cases
      issue("alu",      2'b00, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 5'd5, 32'h4, 32'h0, 0, 1'b0);
      issue("ld0",      2'b01, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 5'd7, 32'h8, 32'h0, 0, 1'b0);
      issue("st3",      2'b00, 1'b1, 1'b0, 32'h0000_0200, 32'h1234_5678, 5'd9, 32'hC, 32'h0, 3, 1'b0);
      issue("ldmax",    2'b01, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 5'd11, 32'h10, 32'h0, MAX_WAIT - 1, 1'b0);
      issue("timeout",  2'b01, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 5'd12, 32'h14, 32'h0, MAX_WAIT, 1'b1);
      issue("ldx0",     2'b01, 1'b0, 1'b1, 32'h0000_0500, 32'h0, 5'd0, 32'h18, 32'h0, 1, 1'b0);
      issue("pc4",      2'b10, 1'b0, 1'b1, 32'h0000_0600, 32'h0, 5'd13, 32'h0000_1004, 32'h0, 0, 1'b0);
      issue("lui",      2'b11, 1'b0, 1'b1, 32'h0000_0700, 32'h0, 5'd14, 32'h0, 32'hABCD_E000, 0, 1'b0);

      // Reset in the second WAIT cycle abandons the access and clears everything
      M_sel_result = 2'b01;
      M_we_dm      = 1'b0;
      M_we_rf      = 1'b1;
      M_alu_o      = 32'h0000_0800;
      M_rf_a3      = 5'd15;
      dm_ack       = 1'b0;
      @(negedge clk);
      check_bus("rstw.c0", 1'b1, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check_bus("rstw.c1", 1'b1, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_bus("rstw.c2", 1'b0, 1'b0);
      @(posedge clk); #1;
      rst        = 1'b0;
      exp_result = 32'h0;
      exp_a3     = 5'd0;
      exp_we     = 1'b0;
      exp_to     = 1'b0;
      check_w("rstw");
      // A full timeout afterwards proves the counter restarted from idle
      issue("rstw.to",  2'b01, 1'b0, 1'b1, 32'h0000_0800, 32'h0, 5'd15, 32'h0, 32'h0, MAX_WAIT, 1'b0);

      // Randomized instruction stream
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            r_wdm = 1'b0;
            case ($urandom_range(0, 2))
               0:       r_sel = 2'b00;
               1:       r_sel = 2'b10;
               default: r_sel = 2'b11;
            endcase
         end else if (kind == 1) begin
            r_wdm = 1'b0;
            r_sel = 2'b01;
         end else begin
            r_wdm = 1'b1;
            r_sel = 2'($urandom_range(0, 3));
         end
         r_a3  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
         r_lat = ($urandom_range(0, 9) == 0) ? MAX_WAIT : $urandom_range(0, 4);
         issue("rand", r_sel, r_wdm, 1'($urandom), $urandom, $urandom, r_a3,
               $urandom, $urandom, r_lat, 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
